// File: rtl/max_product_llr_combine_pkg.sv
// Shared constants, helpers and bundle types for the max-product
// LLR combine stage and its arithmetic sub-modules.
package max_product_pkg;

   // Register levels of max_vector: one per comparator tree level.
   function automatic int MAX_LAT(input int w);
      return (w > 1) ? $clog2(w) : 0;
   endfunction

   localparam int ADD_LAT = 1;

   localparam logic [15:0] FP16_ONE = 16'h3C00;
   localparam logic [15:0] FP16_TWO = 16'h4000;

   // Default bundle shapes: half float, 2 output bits, 8 states.
   typedef logic [1:0][15:0] llr_vec_t;
   typedef llr_vec_t [7:0]   state_llr_t;

endpackage

// File: rtl/max_product_llr_combine_if.sv
// Bus between the state stages and the LLR combine stage.
// slave: combine block side; master: producer / consumer side.
interface max_product_llr_combine_if #(
   parameter int BITS        = 16,
   parameter int STATES      = 8,
   parameter int OUTPUT_BITS = 2,
   parameter int IDXW        = 6
);
   logic in_valid;
   logic [STATES-1:0][OUTPUT_BITS-1:0][BITS-1:0] llr_0_in;
   logic [STATES-1:0][OUTPUT_BITS-1:0][BITS-1:0] llr_1_in;
   logic out_valid;
   logic [OUTPUT_BITS-1:0][BITS-1:0] llr_out;
   logic [OUTPUT_BITS-1:0] hard_bits;
   logic [IDXW-1:0] out_index;
   logic out_last;

   modport master (
      output in_valid, llr_0_in, llr_1_in,
      input  out_valid, llr_out, hard_bits,
      input  out_index, out_last
   );

   modport slave (
      input  in_valid, llr_0_in, llr_1_in,
      output out_valid, llr_out, hard_bits,
      output out_index, out_last
   );
endinterface

// File: rtl/add.sv
// Registered float adder (HALF or SINGLE), truncating rounding.
// Ports: clk, rstn, in_valid, a_i, b_i -> out_valid, sum_o.
module add #(
   parameter int    BITS      = 16,
   parameter string PRECISION = "HALF"
) (
   input  logic clk,
   input  logic rstn,
   input  logic in_valid,
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic out_valid,
   output logic [BITS-1:0] sum_o
);
   localparam int EW = (PRECISION == "SINGLE") ? 8 : 5;
   localparam int MW = BITS - 1 - EW;
   localparam int SW = MW + 5;
   localparam logic [EW:0]   SWL  = SW[EW:0];
   localparam logic [EW+1:0] E1   = {{(EW+1){1'b0}}, 1'b1};
   localparam logic [EW+1:0] EMAX = {2'b00, {EW{1'b1}}};

   logic [BITS-1:0] big, sml, res_d;
   logic [EW-1:0] eb1, es1;
   logic [EW:0] d;
   logic [EW+1:0] e;
   logic [SW-1:0] mb, ms, msh, s;

   always_comb begin
      if (a_i[BITS-2:0] >= b_i[BITS-2:0]) begin
         big = a_i; sml = b_i;
      end else begin
         big = b_i; sml = a_i;
      end
      // Subnormals share the exponent of the smallest normal.
      eb1 = (big[BITS-2:MW] == '0) ? EW'(1) : big[BITS-2:MW];
      es1 = (sml[BITS-2:MW] == '0) ? EW'(1) : sml[BITS-2:MW];
      mb = {1'b0, big[BITS-2:MW] != '0, big[MW-1:0], 3'b000};
      ms = {1'b0, sml[BITS-2:MW] != '0, sml[MW-1:0], 3'b000};
      d = {1'b0, eb1} - {1'b0, es1};
      msh = (d >= SWL) ? '0 : ms >> d;
      s = (big[BITS-1] ^ sml[BITS-1]) ? mb - msh : mb + msh;
      e = {2'b00, eb1};
      if (s[SW-1]) begin
         s = s >> 1;
         e = e + 1'b1;
      end else begin
         for (int i = 0; i < MW+3; i++)
            if (!s[SW-2] && e > E1) begin
               s = s << 1;
               e = e - 1'b1;
            end
      end
      if (s == '0)
         res_d = '0;
      else if (e >= EMAX)
         res_d = {big[BITS-1], {EW{1'b1}}, {MW{1'b0}}};
      else
         res_d = {big[BITS-1],
                  (s[SW-2] ? e[EW-1:0] : {EW{1'b0}}),
                  s[SW-3 -: MW]};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         sum_o     <= '0;
      end else begin
         out_valid <= in_valid;
         sum_o     <= res_d;
      end
   end
endmodule

// File: rtl/max_product_llr_combine_clamp.sv
// Combinational |LLR| clamp keeping the sign; CLAMP=0 disables it.
// Ports: d_i -> q_o.
module llr_clamp #(
   parameter int BITS = 16,
   parameter logic [BITS-1:0] CLAMP = '0
) (
   input  logic [BITS-1:0] d_i,
   output logic [BITS-1:0] q_o
);
   localparam logic [BITS-2:0] LIM = CLAMP[BITS-2:0];

   assign q_o = (CLAMP != '0 && d_i[BITS-2:0] > LIM)
              ? {d_i[BITS-1], LIM} : d_i;
endmodule

// File: rtl/max_vector.sv
// Pipelined float max over WIDTH words, one register per tree level.
// Ports: clk, rstn, in_valid, in_i[WIDTH] -> out_valid, out_o.
module max_vector
   import max_product_pkg::*;
#(
   parameter int BITS  = 16,
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic in_valid,
   input  logic [WIDTH-1:0][BITS-1:0] in_i,
   output logic out_valid,
   output logic [BITS-1:0] out_o
);
   localparam int LV = MAX_LAT(WIDTH);
   localparam int N  = 1 << LV;

   // Sign-magnitude compare; +0 beats -0.
   function automatic logic [BITS-1:0] fmax(
      input logic [BITS-1:0] a, input logic [BITS-1:0] b);
      logic a_gt;
      if (a[BITS-1] != b[BITS-1]) a_gt = !a[BITS-1];
      else if (!a[BITS-1]) a_gt = a[BITS-2:0] > b[BITS-2:0];
      else a_gt = a[BITS-2:0] < b[BITS-2:0];
      return a_gt ? a : b;
   endfunction

   // Heap layout: nodes 0..N-2 registered, N-1..2N-2 are leaves.
   logic [BITS-1:0] nd_q [N > 1 ? N-1 : 1];
   logic [BITS-1:0] all_d [2*N-1];

   always_comb begin
      for (int k = 0; k < 2*N-1; k++) all_d[k] = '0;
      for (int k = 0; k < N-1; k++) all_d[k] = nd_q[k];
      // Padding leaves repeat real inputs, which cannot change a max.
      for (int i = 0; i < N; i++) all_d[N-1+i] = in_i[i % WIDTH];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < N-1; k++) nd_q[k] <= '0;
      end else begin
         for (int k = 0; k < N-1; k++)
            nd_q[k] <= fmax(all_d[2*k+1], all_d[2*k+2]);
      end
   end

   assign out_o = all_d[0];

   if (LV == 0) begin : g_comb
      assign out_valid = in_valid;
   end else begin : g_pipe
      logic [LV-1:0] v_q;
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) v_q <= '0;
         else begin
            v_q[0] <= in_valid;
            for (int i = 1; i < LV; i++) v_q[i] <= v_q[i-1];
         end
      end
      assign out_valid = v_q[LV-1];
   end
endmodule

// File: rtl/max_product_llr_combine.sv
// Max-reduces per-state LLR candidates, forms max1-max0, clamps,
// registers LLR/hard bits and tags frame index/last. Ports: clk, rstn, bus.
module max_product_llr_combine
   import max_product_pkg::*;
#(
   parameter int    BITS        = 16,
   parameter string PRECISION   = "HALF",
   parameter int    STATES      = 8,
   parameter int    OUTPUT_BITS = 2,
   parameter int    FRAME_LEN   = 64,
   parameter logic [BITS-1:0] CLAMP = '0
) (
   input logic clk,
   input logic rstn,
   max_product_llr_combine_if.slave bus
);
   localparam int ML = MAX_LAT(STATES);
   localparam int P  = ML + ADD_LAT;
   localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IW-1:0] LASTI = IW'(FRAME_LEN - 1);

   logic [P-1:0] vl_q;
   logic [P:0]   vin;
   logic [OUTPUT_BITS-1:0] mv1_v, mv0_v, add_v, hard_d;
   logic [OUTPUT_BITS-1:0][BITS-1:0] max1, max0, diff, clmp;

   // vin[k]: valid of the data k register stages into the pipe.
   assign vin = {vl_q, bus.in_valid};

   for (genvar g = 0; g < OUTPUT_BITS; g++) begin : g_bit
      logic [STATES-1:0][BITS-1:0] c1, c0;
      for (genvar s = 0; s < STATES; s++) begin : g_st
         assign c1[s] = bus.llr_1_in[s][g];
         assign c0[s] = bus.llr_0_in[s][g];
      end

      max_vector #(.BITS(BITS), .WIDTH(STATES)) u_max1 (
         .clk(clk), .rstn(rstn), .in_valid(bus.in_valid),
         .in_i(c1), .out_valid(mv1_v[g]), .out_o(max1[g]));

      max_vector #(.BITS(BITS), .WIDTH(STATES)) u_max0 (
         .clk(clk), .rstn(rstn), .in_valid(bus.in_valid),
         .in_i(c0), .out_valid(mv0_v[g]), .out_o(max0[g]));

      // Subtraction as addition of max0 with its sign flipped.
      add #(.BITS(BITS), .PRECISION(PRECISION)) u_add (
         .clk(clk), .rstn(rstn), .in_valid(vin[ML]),
         .a_i(max1[g]),
         .b_i({~max0[g][BITS-1], max0[g][BITS-2:0]}),
         .out_valid(add_v[g]), .sum_o(diff[g]));

      llr_clamp #(.BITS(BITS), .CLAMP(CLAMP)) u_clamp (
         .d_i(diff[g]), .q_o(clmp[g]));

      assign hard_d[g] = ~clmp[g][BITS-1];
   end

   logic ov_q, last_q;
   logic [OUTPUT_BITS-1:0][BITS-1:0] llr_q;
   logic [OUTPUT_BITS-1:0] hard_q;
   logic [IW-1:0] idx_q, cnt_q, cnt_d;

   assign cnt_d = (cnt_q == LASTI) ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vl_q   <= '0;
         ov_q   <= 1'b0;
         last_q <= 1'b0;
         llr_q  <= '0;
         hard_q <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
      end else begin
         vl_q   <= vin[P-1:0];
         ov_q   <= vin[P];
         last_q <= vin[P] && cnt_q == LASTI;
         if (vin[P]) begin
            llr_q  <= clmp;
            hard_q <= hard_d;
            idx_q  <= cnt_q;
            cnt_q  <= cnt_d;
         end
      end
   end

   assign bus.out_valid = ov_q;
   assign bus.out_last  = last_q;
   assign bus.llr_out   = llr_q;
   assign bus.hard_bits = hard_q;
   assign bus.out_index = idx_q;

   a_sub_valid: assert property (@(posedge clk) disable iff (!rstn)
      mv1_v == {OUTPUT_BITS{vin[ML]}} &&
      mv0_v == {OUTPUT_BITS{vin[ML]}} &&
      add_v == {OUTPUT_BITS{vin[P]}});
endmodule

// File: tb/tb_max_product_llr_combine.sv
// Scoreboard bench: two instances (no clamp / CLAMP=4000) on one stimulus.
module tb_max_product_llr_combine;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rstn;
   int cyc = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   max_product_llr_combine_if #(
      .BITS(16), .STATES(2), .OUTPUT_BITS(2), .IDXW(2)) b0 ();
   max_product_llr_combine_if #(
      .BITS(16), .STATES(2), .OUTPUT_BITS(2), .IDXW(2)) b1 ();

   assign b1.in_valid = b0.in_valid;
   assign b1.llr_0_in = b0.llr_0_in;
   assign b1.llr_1_in = b0.llr_1_in;

   max_product_llr_combine #(
      .BITS(16), .PRECISION("HALF"), .STATES(2),
      .OUTPUT_BITS(2), .FRAME_LEN(4), .CLAMP(16'h0000)
   ) dut0 (.clk(clk), .rstn(rstn), .bus(b0));

   max_product_llr_combine #(
      .BITS(16), .PRECISION("HALF"), .STATES(2),
      .OUTPUT_BITS(2), .FRAME_LEN(4), .CLAMP(16'h4000)
   ) dut1 (.clk(clk), .rstn(rstn), .bus(b1));

   typedef logic [1:0][1:0][15:0] st_t;
   typedef struct {
      logic [1:0][15:0] l0;
      logic [1:0][15:0] l1;
      logic [1:0] idx;
      logic last;
      int t;
   } exp_t;

   st_t vl1 [5];
   st_t vl0 [5];
   logic [1:0][15:0] ve0 [5];
   logic [1:0][15:0] ve1 [5];

   exp_t q [$];
   exp_t em;
   logic [1:0] cnt;
   logic [1:0][15:0] h0, h1;
   logic [1:0] hi;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int k);
      exp_t e;
      b0.in_valid = 1'b1;
      b0.llr_1_in = vl1[k];
      b0.llr_0_in = vl0[k];
      e.l0 = ve0[k];
      e.l1 = ve1[k];
      e.idx = cnt;
      e.last = (cnt == 2'd3);
      e.t = cyc;
      q.push_back(e);
      cnt = cnt + 2'd1;
   endtask

   task automatic idle();
      b0.in_valid = 1'b0;
   endtask

   task automatic flush_model();
      q.delete();
      cnt = '0;
      h0 = '0;
      h1 = '0;
      hi = '0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valid0", b0.out_valid, 0);
      chk("rst_llr0", b0.llr_out, 0);
      chk("rst_hard0", b0.hard_bits, 0);
      chk("rst_idx0", b0.out_index, 0);
      chk("rst_last0", b0.out_last, 0);
      chk("rst_valid1", b1.out_valid, 0);
      chk("rst_llr1", b1.llr_out, 0);
      chk("rst_idx1", b1.out_index, 0);
   endtask

   // Monitor: pops one expectation per output, checks holds in gaps.
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (b0.out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out", b0.out_valid, 0);
            end else begin
               em = q.pop_front();
               chk("latency", cyc, em.t + LAT);
               chk("llr0", b0.llr_out, em.l0);
               chk("hard0", b0.hard_bits,
                   {~em.l0[1][15], ~em.l0[0][15]});
               chk("idx0", b0.out_index, em.idx);
               chk("last0", b0.out_last, em.last);
               chk("valid1", b1.out_valid, 1);
               chk("llr1", b1.llr_out, em.l1);
               chk("hard1", b1.hard_bits,
                   {~em.l1[1][15], ~em.l1[0][15]});
               chk("idx1", b1.out_index, em.idx);
               chk("last1", b1.out_last, em.last);
               h0 = em.l0;
               h1 = em.l1;
               hi = em.idx;
            end
         end else begin
            chk("hold_llr0", b0.llr_out, h0);
            chk("hold_llr1", b1.llr_out, h1);
            chk("hold_idx0", b0.out_index, hi);
            chk("hold_last0", b0.out_last, 0);
            chk("idle_valid1", b1.out_valid, 0);
         end
      end
   end

   initial begin
      // Packed as {state1 bit1, state1 bit0, state0 bit1, state0 bit0}.
      vl1[0] = {16'h3800, 16'h4000, 16'h3800, 16'h3C00};
      vl0[0] = {16'h3C00, 16'hBC00, 16'h4200, 16'h3800};
      ve0[0] = {16'hC100, 16'h3E00};
      ve1[0] = {16'hC000, 16'h3E00};
      vl1[1] = {16'hBC00, 16'h0000, 16'h0000, 16'h4400};
      vl0[1] = {16'h3C00, 16'h8000, 16'h4400, 16'h0000};
      ve0[1] = {16'hC400, 16'h4400};
      ve1[1] = {16'hC000, 16'h4000};
      vl1[2] = {16'h3800, 16'h3C00, 16'h3C00, 16'h4000};
      vl0[2] = {16'h3400, 16'hB800, 16'h3C00, 16'h3C00};
      ve0[2] = {16'h0000, 16'h3C00};
      ve1[2] = {16'h0000, 16'h3C00};
      vl1[3] = {16'h3400, 16'hC200, 16'h3A00, 16'hC000};
      vl0[3] = {16'h3000, 16'hC200, 16'hB400, 16'hC400};
      ve0[3] = {16'h3900, 16'h3C00};
      ve1[3] = {16'h3900, 16'h3C00};
      vl1[4] = {16'hBC00, 16'h4200, 16'hB800, 16'h4500};
      vl0[4] = {16'h3400, 16'h4000, 16'h3800, 16'h3C00};
      ve0[4] = {16'hBC00, 16'h4200};
      ve1[4] = {16'hBC00, 16'h4000};

      flush_model();
      rstn = 1'b0;
      b0.in_valid = 1'b0;
      b0.llr_0_in = '0;
      b0.llr_1_in = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      step();
      rstn = 1'b1;

      // Isolated steps.
      step(); issue(0); step(); idle(); repeat (4) step();
      issue(1); step(); idle(); repeat (4) step();

      // Fresh frame: 9 back-to-back steps.
      rstn = 1'b0; flush_model(); step(); step(); rstn = 1'b1;
      step();
      for (int i = 0; i < 9; i++) begin
         issue(i % 5);
         step();
      end
      idle();
      repeat (6) step();

      // Gapped input, valid every third cycle.
      for (int i = 0; i < 4; i++) begin
         issue(i + 1);
         step(); idle(); step(); step();
      end
      repeat (6) step();

      // Reset with two steps in flight, in_valid held during reset.
      issue(3); step(); issue(4); step();
      rstn = 1'b0;
      flush_model();
      issue(0);
      q.delete();
      cnt = '0;
      @(negedge clk);
      chk_reset_outputs();
      step(); idle(); step();
      @(negedge clk);
      chk_reset_outputs();
      step();
      rstn = 1'b1;
      repeat (5) step();
      issue(2); step(); idle();

      for (int n = 0; n < 20 && q.size() != 0; n++) step();
      chk("drain", q.size(), 0);
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
